// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Inter-stage register for the five-stage pipeline. One instance sits between
// each pair of stages (IF/ID, ID/EX, EX/MEM, MEM/WB). The datapath fields are
// concatenated into in_data and the control group into in_ctrl.
//
// Storage is a main register, which drives out_*, plus a skid register that
// catches the one extra entry arriving on the cycle downstream stalls. Since
// in_ready is a flop, a stall never creates a combinational out_ready ->
// in_ready path.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1 on that side. The producer holds valid and its payload stable until
// the transfer happens. Ready can be sampled without looking at valid.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   flush      in   synchronous squash of every held entry (wins over all)
//   in_valid   in   upstream presents an instruction
//   in_ready   out  stage can accept (registered)
//   in_data    in   upstream payload
//   in_ctrl    in   upstream control group
//   out_valid  out  downstream instruction valid
//   out_ready  in   downstream accepts
//   out_data   out  payload; holds its last value while out_valid=0
//   out_ctrl   out  control group; forced to 0 while out_valid=0 (bubble)
//   occupancy  out  number of held entries: 0, 1 or 2
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy
);

   // The state is nothing more than the two valid bits, {skid, main}.
   // Skid valid without main valid is unreachable.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_FULL  = 2'b11
   } state_e;

   // Held entries
   logic              main_valid_q, main_valid_d;
   logic [DATA_W-1:0] main_data_q,  main_data_d;
   logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
   logic              skid_valid_q, skid_valid_d;
   logic [DATA_W-1:0] skid_data_q,  skid_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
   logic              in_ready_q,   in_ready_d;

   // Decoded state, kept as a named signal so it can be probed and bound to
   state_e state_q;
   state_e state_d;

   logic in_fire;
   logic out_fire;

   assign state_q  = state_e'({skid_valid_q, main_valid_q});
   assign state_d  = state_e'({skid_valid_d, main_valid_d});
   assign in_fire  = in_valid & in_ready_q;
   assign out_fire = main_valid_q & out_ready;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid_q <= 1'b0;
         main_data_q  <= '0;
         main_ctrl_q  <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_ctrl_q  <= '0;
         in_ready_q   <= 1'b1;
      end else begin
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         main_ctrl_q  <= main_ctrl_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_ctrl_q  <= skid_ctrl_d;
         in_ready_q   <= in_ready_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      main_ctrl_d  = main_ctrl_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_ctrl_d  = skid_ctrl_q;

      if (flush) begin
         // Squash drops everything, including a same-cycle accept. Payload
         // registers keep their contents; only the valid bits matter.
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  main_valid_d = 1'b1;
                  main_data_d  = in_data;
                  main_ctrl_d  = in_ctrl;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  // Streaming: the new entry replaces the departing one
                  main_data_d = in_data;
                  main_ctrl_d = in_ctrl;
               end else if (in_fire) begin
                  // Downstream stalled: park the newer entry behind main
                  skid_valid_d = 1'b1;
                  skid_data_d  = in_data;
                  skid_ctrl_d  = in_ctrl;
               end else if (out_fire) begin
                  main_valid_d = 1'b0;
               end
            end
            ST_FULL: begin
               // in_ready is low here, so only the output side can move
               if (out_fire) begin
                  main_data_d  = skid_data_q;
                  main_ctrl_d  = skid_ctrl_q;
                  skid_valid_d = 1'b0;
               end
            end
            default: begin
               main_valid_d = 1'b0;
               skid_valid_d = 1'b0;
            end
         endcase
      end

      // Ready for the next cycle follows the skid slot being free after this
      // edge, which is what makes in_ready a plain flop.
      in_ready_d = ~skid_valid_d;
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   always_comb begin
      out_valid = main_valid_q;
      out_data  = main_data_q;
      // Bubble insertion: an invalid slot must never carry live control bits
      out_ctrl  = main_ctrl_q & {CTRL_W{main_valid_q}};
      in_ready  = in_ready_q;
      occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int RAND_CYCLES = 10000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Reference model: the stage is a FIFO of at most two entries that a flush
  // empties. Each entry is {ctrl, data}.
  logic [CW+DW-1:0] exp_q[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      chk("occupancy", 64'(occupancy), 64'(exp_q.size()));
      chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
      if (!out_valid) chk("bubble_ctrl", 64'(out_ctrl), 64'd0);
      // monitor: downstream takes an entry
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 64'({out_ctrl, out_data}), 64'hDEAD_BEEF_DEAD);
        end else begin
          chk("out_entry", 64'({out_ctrl, out_data}), 64'(exp_q[0]));
          void'(exp_q.pop_front());
        end
      end
      // stimulus side: the upstream transfer joins the queue unless squashed
      if (flush) exp_q.delete();
      else if (in_valid && exp_q.size() < 2 && in_ready) exp_q.push_back({in_ctrl, in_data});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic hold;
    logic ordy;
    logic r0;

    do_reset();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);

    // Streaming: one entry per cycle, each visible one cycle later
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, DW'(32'h10 + i), 4'hF, 1'b1, 1'b0);
      step();
      chk("stream_data", 64'(out_data), 64'(32'h10 + i));
      chk("stream_ctrl", 64'(out_ctrl), 64'hF);
      chk("stream_occ", 64'(occupancy), 64'd1);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    chk("stream_drained", 64'(out_valid), 64'd0);

    // Back-pressure into the skid slot
    drive(1'b1, 32'hA1, 4'h3, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hA2, 4'h5, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    chk("bp_occ", 64'(occupancy), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_data", 64'(out_data), 64'hA1);
    step();
    chk("bp_hold_data", 64'(out_data), 64'hA1);
    out_ready = 1'b1;
    step();
    chk("bp_second", 64'(out_data), 64'hA2);
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    chk("bp_occ1", 64'(occupancy), 64'd1);
    step();
    chk("bp_empty", 64'(occupancy), 64'd0);

    // Flush while FULL, with an offered entry that must vanish
    drive(1'b1, 32'hB1, 4'h7, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hB2, 4'h9, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hB3, 4'hB, 1'b0, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    chk("flush_occ", 64'(occupancy), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ctrl", 64'(out_ctrl), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);
    repeat (3) step();

    // Bubble masking keeps data, clears control
    drive(1'b1, 32'hC0, 4'hF, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    chk("bubble_valid", 64'(out_valid), 64'd0);
    chk("bubble_ctrl0", 64'(out_ctrl), 64'd0);
    chk("bubble_data", 64'(out_data), 64'hC0);

    // Asynchronous reset with two entries held
    drive(1'b1, 32'hD1, 4'h1, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hD2, 4'h2, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    chk("pre_rst_occ", 64'(occupancy), 64'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("arst_out_data", 64'(out_data), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_occ", 64'(occupancy), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Random traffic; ready is first driven to the opposite value and then
    // flipped, so any same-cycle dependency of in_ready would show up.
    hold = 1'b0;
    for (int n = 0; n < RAND_CYCLES; n++) begin
      ordy = 1'($urandom_range(0, 1));
      if (hold) begin
        out_ready = ~ordy;
        flush = ($urandom_range(0, 99) < 5);
      end else begin
        drive(1'($urandom_range(0, 1)), DW'($urandom), CW'($urandom_range(0, 15)),
              ~ordy, ($urandom_range(0, 99) < 5));
      end
      #1 r0 = in_ready;
      out_ready = ordy;
      #1 chk("in_ready_indep", 64'(in_ready), 64'(r0));
      @(posedge clk);
      hold = in_valid && !r0 && !flush;
      #1;
    end

    // Drain
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (4) step();
    chk("final_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
